// File: rtl/bench_sig_pkg.sv
// ---------------------------------------------------------------------------
// bench_sig_pkg
// Shared definitions for the benchmark signature analyser and the
// harnesses that reuse its MISR.
//   - IN_W / OUT_W : benchmark input / output vector widths. These are fixed
//                    because the LFSR and MISR tap positions are fixed.
//   - Tap positions: LFSR x^33 + x^20 + 1 (bits 32, 19),
//                    MISR x^25 + x^22 + 1 (bits 24, 21).
//   - state_t      : analyser FSM states.
//   - lfsr_step / misr_step : one-clock update functions.
// ---------------------------------------------------------------------------
package bench_sig_pkg;

    localparam int IN_W  = 33;
    localparam int OUT_W = 25;

    localparam int LFSR_TAP_A = 32;
    localparam int LFSR_TAP_B = 19;
    localparam int MISR_TAP_A = 24;
    localparam int MISR_TAP_B = 21;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Fibonacci LFSR: shift left, feedback into bit 0.
    function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] cur);
        return {cur[IN_W-2:0], cur[LFSR_TAP_A] ^ cur[LFSR_TAP_B]};
    endfunction

    // MISR: shift left with feedback into bit 0, then fold in the response.
    function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] cur,
                                                   input logic [OUT_W-1:0] data);
        logic [OUT_W-1:0] shifted;
        shifted = {cur[OUT_W-2:0], cur[MISR_TAP_A] ^ cur[MISR_TAP_B]};
        return shifted ^ data;
    endfunction

endpackage

// File: rtl/bench_sig_analyzer_misr.sv
// ---------------------------------------------------------------------------
// bench_misr
// Multiple-input signature register compacting OUT_W-bit responses.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset (register -> 0)
//   i_clear   in   synchronous clear to 0 (has priority over i_enable)
//   i_enable  in   fold i_data into the signature this cycle
//   i_data    in   OUT_W response word
//   o_sig     out  current signature register
// ---------------------------------------------------------------------------
module bench_misr
    import bench_sig_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [OUT_W-1:0] i_data,
    output logic [OUT_W-1:0] o_sig
);

    logic [OUT_W-1:0] r_sig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (i_clear) begin
            r_sig <= '0;
        end else if (i_enable) begin
            r_sig <= misr_step(r_sig, i_data);
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/bench_sig_analyzer.sv
// ---------------------------------------------------------------------------
// bench_sig_analyzer
// Drives LFSR test vectors into a combinational benchmark, compacts the
// responses in a MISR and compares the final signature against a golden one.
// Each pattern occupies SETTLE+1 WAIT cycles followed by one CAPTURE cycle.
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   start         in   run request, sampled only in IDLE
//   pattern_count in   number of patterns (sampled with start)
//   seed          in   LFSR seed (sampled with start, 0 is replaced by 1)
//   golden_sig    in   expected signature (sampled on entry to DONE)
//   dut_in        out  vector applied to the benchmark (0 when idle)
//   dut_out       in   benchmark response
//   busy          out  run in progress
//   done          out  one-cycle completion pulse
//   signature     out  final MISR value, held until the next accepted start
//   match         out  signature == golden_sig, held likewise
// ---------------------------------------------------------------------------
module bench_sig_analyzer
    import bench_sig_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int SETTLE = 1    // 0..15
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] pattern_count,
    input  logic [IN_W-1:0]  seed,
    input  logic [OUT_W-1:0] golden_sig,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] signature,
    output logic             match
);

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    state_t           r_state;
    state_t           w_state_next;
    logic [IN_W-1:0]  r_lfsr;
    logic [CNT_W-1:0] r_remaining;
    logic [3:0]       r_settle_cnt;
    logic [IN_W-1:0]  r_dut_in;
    logic             r_busy;
    logic             r_done;
    logic [OUT_W-1:0] r_signature;
    logic             r_match;

    logic             w_misr_clear;
    logic             w_misr_enable;
    logic [OUT_W-1:0] w_misr;
    logic [OUT_W-1:0] w_misr_next;
    logic [IN_W-1:0]  w_lfsr_next;
    logic [IN_W-1:0]  w_seed_fixed;
    logic             w_last;

    bench_misr u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_misr_clear),
        .i_enable (w_misr_enable),
        .i_data   (dut_out),
        .o_sig    (w_misr)
    );

    // The signature is registered on the same edge that folds in the last
    // response, so the post-update MISR value is needed here as well.
    assign w_misr_next  = misr_step(w_misr, dut_out);
    assign w_lfsr_next  = lfsr_step(r_lfsr);
    assign w_seed_fixed = (seed == '0) ? IN_W'(1) : seed;
    assign w_last       = (r_remaining == CNT_W'(1));

    // Next-state logic
    always_comb begin
        w_state_next  = r_state;
        w_misr_clear  = 1'b0;
        w_misr_enable = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_misr_clear = 1'b1;
                    w_state_next = (pattern_count == '0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_settle_cnt == SETTLE_L) begin
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_misr_enable = 1'b1;
                w_state_next  = w_last ? ST_DONE : ST_WAIT;
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_lfsr       <= '0;
            r_remaining  <= '0;
            r_settle_cnt <= '0;
            r_dut_in     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_signature  <= '0;
            r_match      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_WAIT) || (w_state_next == ST_CAPTURE);
            r_done  <= (w_state_next == ST_DONE);

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (pattern_count == '0) begin
                            // Empty run: signature of nothing is 0.
                            r_signature <= '0;
                            r_match     <= (golden_sig == '0);
                        end else begin
                            r_lfsr       <= w_seed_fixed;
                            r_dut_in     <= w_seed_fixed;
                            r_remaining  <= pattern_count;
                            r_settle_cnt <= '0;
                            r_signature  <= '0;
                            r_match      <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_settle_cnt != SETTLE_L) begin
                        r_settle_cnt <= r_settle_cnt + 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    r_lfsr       <= w_lfsr_next;
                    r_remaining  <= r_remaining - CNT_W'(1);
                    r_settle_cnt <= '0;
                    if (w_last) begin
                        r_dut_in    <= '0;
                        r_signature <= w_misr_next;
                        r_match     <= (w_misr_next == golden_sig);
                    end else begin
                        r_dut_in <= w_lfsr_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dut_in    = r_dut_in;
    assign busy      = r_busy;
    assign done      = r_done;
    assign signature = r_signature;
    assign match     = r_match;

endmodule

// File: tb/tb_bench_sig_analyzer.sv
// ---------------------------------------------------------------------------
// tb_bench_sig_analyzer
// Directed runs of the signature analyser. Each run pushes its expected
// signature/match onto a scoreboard queue; an independent monitor pops and
// compares whenever done is presented.
// ---------------------------------------------------------------------------
module tb_bench_sig_analyzer;

    localparam int SETTLE = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] pattern_count = '0;
    logic [32:0] seed = '0;
    logic [24:0] golden_sig = '0;
    logic [32:0] dut_in;
    logic [24:0] dut_out;
    logic        busy;
    logic        done;
    logic [24:0] signature;
    logic        match;

    // Benchmark-side stimulus control
    logic        tb_loop = 1'b0;
    logic        tb_flip = 1'b0;
    logic [24:0] tb_const = '0;
    logic [32:0] tb_flip_vec = '0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [24:0] sig;
        logic        match;
    } exp_t;
    exp_t sb_q[$];

    logic [32:0] exp_vec_q[$];
    logic [32:0] seen_q[$];

    always #5 clk = ~clk;

    bench_sig_analyzer #(.CNT_W(16), .SETTLE(SETTLE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .pattern_count (pattern_count),
        .seed          (seed),
        .golden_sig    (golden_sig),
        .dut_in        (dut_in),
        .dut_out       (dut_out),
        .busy          (busy),
        .done          (done),
        .signature     (signature),
        .match         (match)
    );

    // Stand-in combinational benchmark for the loop-back runs.
    function automatic logic [24:0] bench_fn(input logic [32:0] v);
        return v[24:0] ^ v[32:8] ^ {v[7:0], v[32:16]} ^ (v[24:0] & v[31:7]);
    endfunction

    function automatic logic [32:0] m_lfsr(input logic [32:0] v);
        return {v[31:0], v[32] ^ v[19]};
    endfunction

    function automatic logic [24:0] m_misr(input logic [24:0] m, input logic [24:0] d);
        logic [24:0] r;
        r[0] = m[24] ^ m[21] ^ d[0];
        for (int i = 1; i < 25; i++) r[i] = m[i-1] ^ d[i];
        return r;
    endfunction

    function automatic logic [32:0] m_vec_at(input logic [32:0] sd, input int k);
        logic [32:0] v;
        v = (sd == 0) ? 33'h1 : sd;
        for (int i = 0; i < k; i++) v = m_lfsr(v);
        return v;
    endfunction

    function automatic logic [24:0] m_sig(input int n, input logic [32:0] sd,
                                          input logic flip, input int flip_idx);
        logic [32:0] v;
        logic [24:0] m;
        logic [24:0] o;
        v = (sd == 0) ? 33'h1 : sd;
        m = '0;
        for (int i = 0; i < n; i++) begin
            o = bench_fn(v);
            if (flip && i == flip_idx) o = o ^ 25'h1;
            m = m_misr(m, o);
            v = m_lfsr(v);
        end
        return m;
    endfunction

    always_comb begin
        if (tb_loop)
            dut_out = bench_fn(dut_in) ^ ((tb_flip && dut_in == tb_flip_vec) ? 25'h1 : 25'h0);
        else
            dut_out = tb_const;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Scoreboard monitor: every done pulse must correspond to a queued run.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.name, "_signature"}, 64'(signature), 64'(e.sig));
                chk({e.name, "_match"}, 64'(match), 64'(e.match));
                chk({e.name, "_busy_in_done"}, 64'(busy), 64'd0);
            end
        end
    end

    task automatic run(input string name, input int n, input logic [32:0] sd,
                       input logic [24:0] gold, input logic [24:0] exp_sig,
                       input logic exp_match, input logic check_vec);
        int cyc;
        int limit;
        logic saw_busy;
        exp_t e;
        e.name = name; e.sig = exp_sig; e.match = exp_match;
        sb_q.push_back(e);
        seen_q.delete();
        saw_busy = 1'b0;
        limit = (SETTLE + 2) * n + 20;
        @(posedge clk); #1;
        start = 1'b1; pattern_count = 16'(n); seed = sd; golden_sig = gold;
        @(posedge clk); #1;
        start = 1'b0;
        if (n != 0) begin
            chk({name, "_sig_cleared"}, 64'(signature), 64'd0);
            chk({name, "_match_cleared"}, 64'(match), 64'd0);
        end
        cyc = 0;
        while (!done && cyc < limit) begin
            if (busy) begin
                saw_busy = 1'b1;
                if (seen_q.size() == 0 || seen_q[$] != dut_in) seen_q.push_back(dut_in);
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, "_latency"}, 64'(cyc), 64'((SETTLE + 2) * n));
        if (n == 0) chk({name, "_busy_never"}, 64'(saw_busy), 64'd0);
        if (check_vec) begin
            chk({name, "_vec_count"}, 64'(seen_q.size()), 64'(exp_vec_q.size()));
            for (int i = 0; i < exp_vec_q.size() && i < seen_q.size(); i++)
                chk($sformatf("%s_vec%0d", name, i), 64'(seen_q[i]), 64'(exp_vec_q[i]));
        end
        @(posedge clk); #1;
        chk({name, "_done_one_cycle"}, 64'(done), 64'd0);
        chk({name, "_sig_hold"}, 64'(signature), 64'(exp_sig));
        chk({name, "_dut_in_idle"}, 64'(dut_in), 64'd0);
    endtask

    initial begin
        logic [24:0] clean_sig;
        logic [24:0] flip_sig;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dut_in", 64'(dut_in), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_signature", 64'(signature), 64'd0);
        chk("reset_match", 64'(match), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // N=1, seed=1, response 1 -> signature 1, golden 1 matches
        tb_const = 25'h1;
        exp_vec_q = '{33'h1};
        run("n1", 1, 33'h1, 25'h1, 25'h1, 1'b1, 1'b1);

        // N=2: vectors 1,2; signature 3; golden 2 mismatches
        exp_vec_q = '{33'h1, 33'h2};
        run("n2", 2, 33'h1, 25'h2, 25'h3, 1'b0, 1'b1);

        // N=4, seed 0 forced to 1, response 0 -> signature 0
        tb_const = 25'h0;
        exp_vec_q = '{33'h1, 33'h2, 33'h4, 33'h8};
        run("n4_seed0", 4, 33'h0, 25'h0, 25'h0, 1'b1, 1'b1);

        // Empty run: done next cycle, no busy
        run("n0", 0, 33'h5, 25'h0, 25'h0, 1'b1, 1'b0);

        // Reset in the middle of a long run
        tb_const = 25'h1;
        @(posedge clk); #1;
        start = 1'b1; pattern_count = 16'd100; seed = 33'h1; golden_sig = 25'h0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #2;
        chk("midrun_busy_before_reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_dut_in", 64'(dut_in), 64'd0);
        chk("midrun_reset_busy", 64'(busy), 64'd0);
        chk("midrun_reset_done", 64'(done), 64'd0);
        chk("midrun_reset_signature", 64'(signature), 64'd0);
        chk("midrun_reset_match", 64'(match), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        exp_vec_q = '{33'h1};
        run("after_reset_n1", 1, 33'h1, 25'h1, 25'h1, 1'b1, 1'b1);

        // Loop-back through the stand-in benchmark
        clean_sig = m_sig(1000, 33'h1ABCD, 1'b0, 0);
        flip_sig  = m_sig(1000, 33'h1ABCD, 1'b1, 500);
        chk("model_flip_differs", 64'(clean_sig != flip_sig), 64'd1);
        tb_loop = 1'b1;
        run("loop_clean", 1000, 33'h1ABCD, clean_sig, clean_sig, 1'b1, 1'b0);
        tb_flip_vec = m_vec_at(33'h1ABCD, 500);
        tb_flip = 1'b1;
        run("loop_flip", 1000, 33'h1ABCD, clean_sig, flip_sig, 1'b0, 1'b0);
        tb_flip = 1'b0;
        tb_loop = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
